// File: rtl/reset_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sync_pkg
//  Description : Shared types and helpers for the reset_sync_bank reset
//                conditioner: per-channel state encoding, width helper and
//                the largest supported hold-off count.
//  Revision    : 1.0  initial release
// ============================================================================
package reset_sync_pkg;

    // Largest hold-off count a channel can be configured with.
    localparam int HOLD_MAX = 255;

    typedef enum logic [1:0] {
        ASSERT   = 2'd0,  // request active or synchroniser still filling
        HOLDOFF  = 2'd1,  // synchronised release seen, stretching
        WAIT     = 2'd2,  // stretched, waiting for upstream channel
        RELEASED = 2'd3   // reset deasserted
    } chan_state_e;

    // Ceiling log2 with a floor of 1, so a zero-range counter still has a bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sync_chan.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sync_chan
//  Description : One reset channel: asynchronous assertion, STAGES-deep
//                release synchroniser, HOLD-cycle stretch, optional release
//                permit from an upstream channel, and output polarity.
//  Ports       : clk_i          clock
//                rst_i          active-high async request (clears all flops)
//                permit_i       1 = channel may release on the next edge
//                rst_out_o      conditioned reset, polarity OUT_ACTIVE_LOW
//                rst_active_o   1 = channel held in reset
//  Revision    : 1.0  initial release
// ============================================================================
module reset_sync_chan
    import reset_sync_pkg::*;
#(
    parameter int STAGES         = 2,
    parameter int HOLD           = 8,
    parameter bit OUT_ACTIVE_LOW = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic permit_i,
    output logic rst_out_o,
    output logic rst_active_o
);

    localparam int              CW        = clog2_min1(HOLD + 1);
    localparam logic [CW-1:0]   HOLD_LAST = (HOLD > 0) ? CW'(HOLD - 1) : '0;
    localparam logic [CW-1:0]   HOLD_SAT  = CW'(HOLD);
    localparam logic            ASSERTED  = !OUT_ACTIVE_LOW;

    // Release synchroniser; the first stage samples a constant 1.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    chan_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              active_q, active_d;
    logic              ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            state_q  <= ASSERT;
            cnt_q    <= '0;
            out_q    <= ASSERTED;
            active_q <= 1'b1;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], 1'b1};
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;

        case (state_q)
            ASSERT: begin
                if (sync_q[STAGES-1]) begin
                    if (HOLD == 0) begin
                        ready = 1'b1;
                    end else begin
                        state_d = HOLDOFF;
                        cnt_d   = '0;
                    end
                end
            end
            HOLDOFF: begin
                if (cnt_q != HOLD_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // The edge that advances cnt to HOLD is also the edge that
                // leaves HOLDOFF, so WAIT is skipped when release is permitted
                // and the overall latency stays STAGES+HOLD+1 edges.
                if (cnt_q == HOLD_LAST) begin
                    ready = 1'b1;
                end
            end
            WAIT: begin
                ready = 1'b1;
            end
            RELEASED: begin
                state_d = RELEASED;
            end
            default: begin
                state_d = ASSERT;
            end
        endcase

        if (ready) begin
            state_d = permit_i ? RELEASED : WAIT;
        end

        // Outputs come straight from flops so release is glitch-free.
        active_d = (state_d != RELEASED);
        out_d    = active_d ? ASSERTED : !ASSERTED;
    end

    assign rst_out_o    = out_q;
    assign rst_active_o = active_q;

endmodule
`default_nettype wire

// File: rtl/reset_sync_bank.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sync_bank
//  Description : Multi-channel reset conditioner. Each channel is asserted
//                asynchronously, released synchronously to clk_i and
//                stretched by HOLD cycles; optional ordered release 0->NCH-1.
//  Ports       : clk_i          clock
//                asyncreset_i   global async active-high reset, all channels
//                rst_in_i       per-channel requests, polarity IN_ACTIVE_LOW
//                rst_out_o      conditioned resets, polarity OUT_ACTIVE_LOW
//                rst_active_o   1 = channel held in reset
//                all_released_o 1 = every channel released
//  Revision    : 1.0  initial release
// ============================================================================
module reset_sync_bank
    import reset_sync_pkg::*;
#(
    parameter int             NCH            = 4,
    parameter int             STAGES         = 2,
    parameter int             HOLD           = 8,
    parameter logic [NCH-1:0] IN_ACTIVE_LOW  = {NCH{1'b1}},
    parameter logic [NCH-1:0] OUT_ACTIVE_LOW = {NCH{1'b1}},
    parameter bit             SEQ            = 1'b0
) (
    input  logic           clk_i,
    input  logic           asyncreset_i,
    input  logic [NCH-1:0] rst_in_i,
    output logic [NCH-1:0] rst_out_o,
    output logic [NCH-1:0] rst_active_o,
    output logic           all_released_o
);

    localparam int HOLD_C = (HOLD > HOLD_MAX) ? HOLD_MAX : HOLD;

    logic [NCH-1:0] req;
    logic [NCH-1:0] permit;
    logic [NCH-1:0] active;

    // Normalise every request to active-high and fold in the global reset.
    assign req = {NCH{asyncreset_i}} | (rst_in_i ^ IN_ACTIVE_LOW);

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            if (i == 0 || !SEQ) begin : g_free
                assign permit[i] = 1'b1;
            end else begin : g_seq
                // Only gates release; a later upstream re-assert leaves an
                // already released channel alone.
                assign permit[i] = ~active[i-1];
            end

            reset_sync_chan #(
                .STAGES         (STAGES),
                .HOLD           (HOLD_C),
                .OUT_ACTIVE_LOW (OUT_ACTIVE_LOW[i])
            ) u_chan (
                .clk_i        (clk_i),
                .rst_i        (req[i]),
                .permit_i     (permit[i]),
                .rst_out_o    (rst_out_o[i]),
                .rst_active_o (active[i])
            );
        end
    endgenerate

    assign rst_active_o   = active;
    assign all_released_o = ~|active;

endmodule
`default_nettype wire
